// File: rtl/syr2k_io_wrapper.sv
// Self-running syr2k test top: builds operands from indices, computes the lower
// triangle of D = BETA*C + ALPHA*(A*B^T + B*A^T) and streams each word out as nibbles.
module syr2k_io_wrapper (
  input  logic       clk_p,
  input  logic       clk_n,
  input  logic       ap_rst,
  output logic       probe_out,
  output logic [3:0] data_out,
  output logic       data_valid
);

  localparam int unsigned N     = 4;
  localparam int unsigned M     = 4;
  localparam int unsigned ALPHA = 3;
  localparam int unsigned BETA  = 2;
  localparam int unsigned IW    = 2;   // row/column index width
  localparam int unsigned KW    = 2;   // inner index width
  localparam int unsigned OW    = 16;  // operand width
  localparam int unsigned DW    = 32;  // result width
  localparam int unsigned NIB   = 4;
  localparam int unsigned SW    = DW - NIB;
  localparam int unsigned CW    = 3;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_WRITE, S_DONE} state_t;

  // Differential input buffer; the legs are always complementary.
  logic ap_clk;
  assign ap_clk = clk_p & ~clk_n;

  state_t           state_q, state_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d;
  logic [KW-1:0]    k_q, k_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [SW-1:0]    sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NIB-1:0]   dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             probe_q, probe_d;

  logic [OW-1:0]    a_ik, a_jk, b_ik, b_jk, c_ij;
  logic [DW-1:0]    term;
  logic [DW-1:0]    D_out_din;
  logic             D_out_write;
  logic             D_out_full;
  logic             ap_done;

  // Operand generators and the per-k rank-2 contribution.
  always_comb begin
    a_ik = OW'(i_q) + OW'(k_q);
    a_jk = OW'(j_q) + OW'(k_q);
    b_ik = OW'(i_q) + (OW'(k_q) << 1);
    b_jk = OW'(j_q) + (OW'(k_q) << 1);
    c_ij = OW'(1);
    term = DW'(a_ik) * DW'(b_jk) + DW'(b_ik) * DW'(a_jk);
    D_out_din = DW'(BETA) * DW'(c_ij) + DW'(ALPHA) * acc_q;
  end

  assign D_out_full  = dvalid_q;
  assign D_out_write = (state_q == S_WRITE) && !D_out_full;
  assign ap_done     = (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    probe_d  = probe_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_COMPUTE;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        acc_d   = '0;
      end
      S_COMPUTE: begin
        acc_d = acc_q + term;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(M - 1)) begin
          k_d     = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Hold until the serializer drains, then step row-major over j <= i.
        if (D_out_write) begin
          acc_d   = '0;
          state_d = S_COMPUTE;
          if (j_q == i_q) begin
            if (i_q == IW'(N - 1)) begin
              state_d = S_DONE;
            end else begin
              i_d = i_q + IW'(1);
              j_d = '0;
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Serializer: LSB nibble first, eight consecutive cycles per word.
    if (D_out_write) begin
      dout_d   = D_out_din[NIB-1:0];
      sh_d     = D_out_din[DW-1:NIB];
      cnt_d    = CW'(7);
      dvalid_d = 1'b1;
      probe_d  = ^D_out_din;
    end else if (cnt_q != '0) begin
      dout_d = sh_q[NIB-1:0];
      sh_d   = {{NIB{1'b0}}, sh_q[SW-1:NIB]};
      cnt_d  = cnt_q - CW'(1);
    end else begin
      dout_d   = '0;
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      probe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      probe_q  <= probe_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dvalid_q;
  assign probe_out  = probe_q;

endmodule

// File: tb/tb_syr2k_io_wrapper.sv
// Directed bench for syr2k_io_wrapper: reset, first words, run length,
// repeatability against a loop-based golden model, and mid-word reset.
module tb_syr2k_io_wrapper;

  logic       clk_p = 1'b0;
  logic       clk_n = 1'b1;
  logic       ap_rst;
  logic       probe_out;
  logic [3:0] data_out;
  logic       data_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] gold [10];
  logic [31:0] words [2][10];

  syr2k_io_wrapper dut (
    .clk_p      (clk_p),
    .clk_n      (clk_n),
    .ap_rst     (ap_rst),
    .probe_out  (probe_out),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  always #5 begin
    clk_p = ~clk_p;
    clk_n = ~clk_p;
  end

  function automatic logic [31:0] golden(input int i, input int j);
    logic [31:0] acc;
    logic [31:0] a_ik, a_jk, b_ik, b_jk;
    acc = 32'd0;
    for (int k = 0; k < 4; k++) begin
      a_ik = 32'(i + k);
      a_jk = 32'(j + k);
      b_ik = 32'(i + 2 * k);
      b_jk = 32'(j + 2 * k);
      acc  = acc + a_ik * b_jk + b_ik * a_jk;
    end
    return 32'd2 * 32'd1 + 32'd3 * acc;
  endfunction

  task automatic step();
    @(posedge clk_p);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    #2 ap_rst = 1'b0;
    for (int c = 0; c < 3; c++) step();
    checks += 5;
    if (data_out !== 4'h0) begin errors++; $display("FAIL reset_data_out got %h want 0", data_out); end
    if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    if (probe_out !== 1'b0) begin errors++; $display("FAIL reset_probe got %b want 0", probe_out); end
    if (dut.D_out_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", dut.D_out_write); end
    if (dut.ap_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", dut.ap_done); end
    @(negedge clk_p);
    ap_rst = 1'b1;
    begin
      bit early;
      early = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        step();
        if (c < 5 && dut.D_out_write !== 1'b0) early = 1'b1;
      end
      checks += 3;
      if (early) begin errors++; $display("FAIL first_write_early got early write want none before cycle 6"); end
      if (dut.D_out_write !== 1'b1) begin errors++; $display("FAIL first_write_cycle got %b want 1 on cycle 6", dut.D_out_write); end
      if (dut.D_out_din !== 32'h000000AA) begin errors++; $display("FAIL first_word got %h want 000000aa", dut.D_out_din); end
    end
  endtask

  task automatic test_first_words();
    logic [31:0] w0, w1;
    logic [3:0]  exp_nib;
    int t0, t1;
    bit found;
    w0 = 32'h000000AA;
    w1 = 32'h000000E0;
    t0 = cyc;
    for (int n = 0; n < 8; n++) begin
      step();
      exp_nib = w0[4*n +: 4];
      checks++;
      if (data_valid !== 1'b1 || data_out !== exp_nib) begin
        errors++;
        $display("FAIL word0_nibble%0d got v=%b d=%h want v=1 d=%h", n, data_valid, data_out, exp_nib);
      end
    end
    checks++;
    if (probe_out !== 1'b0) begin errors++; $display("FAIL probe_word0 got %b want 0", probe_out); end
    found = 1'b0;
    for (int b = 0; b < 40 && !found; b++) begin
      step();
      if (dut.D_out_write === 1'b1) found = 1'b1;
    end
    t1 = cyc;
    checks += 3;
    if (!found) begin errors++; $display("FAIL word1_timeout got no write want write"); end
    if (t1 - t0 != 9) begin errors++; $display("FAIL word1_spacing got %0d want 9", t1 - t0); end
    if (dut.D_out_din !== w1) begin errors++; $display("FAIL word1_value got %h want %h", dut.D_out_din, w1); end
    for (int n = 0; n < 8; n++) begin
      step();
      exp_nib = w1[4*n +: 4];
      checks++;
      if (data_valid !== 1'b1 || data_out !== exp_nib) begin
        errors++;
        $display("FAIL word1_nibble%0d got v=%b d=%h want v=1 d=%h", n, data_valid, data_out, exp_nib);
      end
    end
    checks++;
    if (probe_out !== 1'b1) begin errors++; $display("FAIL probe_word1 got %b want 1", probe_out); end
    step();
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL word1_valid_len got %b want 0 after 8 nibbles", data_valid); end
  endtask

  task automatic test_back_to_back();
    bit found;
    found = 1'b0;
    for (int b = 0; b < 300 && !found; b++) begin
      step();
      if (dut.ap_done === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL runs_wait_done got no done want done"); end
    for (int r = 0; r < 2; r++) begin
      int nw, last_w, min_sp, done_cyc;
      bit overlap, got_done;
      nw = 0; last_w = -100; min_sp = 1000; done_cyc = -1;
      overlap = 1'b0; got_done = 1'b0;
      step();
      checks++;
      if (dut.ap_done !== 1'b0) begin errors++; $display("FAIL run%0d_done_width got %b want 0", r, dut.ap_done); end
      for (int b = 0; b < 300 && !got_done; b++) begin
        step();
        if (dut.D_out_write === 1'b1) begin
          if (nw < 10) words[r][nw] = dut.D_out_din;
          if (nw > 0 && cyc - last_w < min_sp) min_sp = cyc - last_w;
          if (data_valid !== 1'b0) overlap = 1'b1;
          last_w = cyc;
          nw++;
        end
        if (dut.ap_done === 1'b1) begin
          got_done = 1'b1;
          done_cyc = cyc;
        end
      end
      checks += 5;
      if (!got_done) begin errors++; $display("FAIL run%0d_timeout got no done want done", r); end
      if (nw != 10) begin errors++; $display("FAIL run%0d_length got %0d want 10", r, nw); end
      if (min_sp < 9) begin errors++; $display("FAIL run%0d_spacing got %0d want >=9", r, min_sp); end
      if (done_cyc != last_w + 1) begin errors++; $display("FAIL run%0d_done_timing got %0d want %0d", r, done_cyc, last_w + 1); end
      if (overlap) begin errors++; $display("FAIL run%0d_overlap got overlapping words want none", r); end
    end
    for (int w = 0; w < 10; w++) begin
      checks += 2;
      if (words[0][w] !== gold[w]) begin errors++; $display("FAIL run0_word%0d got %h want %h", w, words[0][w], gold[w]); end
      if (words[1][w] !== words[0][w]) begin errors++; $display("FAIL repeat_word%0d got %h want %h", w, words[1][w], words[0][w]); end
    end
  endtask

  task automatic test_midreset();
    bit found;
    int nw;
    found = 1'b0;
    nw = 0;
    for (int b = 0; b < 300 && !found; b++) begin
      step();
      if (dut.D_out_write === 1'b1) begin
        nw++;
        if (nw == 2) found = 1'b1;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_wait_word2 got %0d writes want 2", nw); end
    for (int n = 0; n < 3; n++) step();
    checks++;
    if (data_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", data_valid); end
    #1 ap_rst = 1'b0;
    #1;
    checks += 5;
    if (data_out !== 4'h0) begin errors++; $display("FAIL mid_data_out got %h want 0", data_out); end
    if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_data_valid got %b want 0", data_valid); end
    if (probe_out !== 1'b0) begin errors++; $display("FAIL mid_probe got %b want 0", probe_out); end
    if (dut.D_out_write !== 1'b0) begin errors++; $display("FAIL mid_write got %b want 0", dut.D_out_write); end
    if (dut.ap_done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", dut.ap_done); end
    step();
    step();
    @(negedge clk_p);
    ap_rst = 1'b1;
    begin
      bit early;
      early = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        step();
        if (c < 5 && dut.D_out_write !== 1'b0) early = 1'b1;
      end
      checks += 3;
      if (early) begin errors++; $display("FAIL mid_restart_early got early write want none before cycle 6"); end
      if (dut.D_out_write !== 1'b1) begin errors++; $display("FAIL mid_restart_cycle got %b want 1", dut.D_out_write); end
      if (dut.D_out_din !== 32'h000000AA) begin errors++; $display("FAIL mid_restart_word got %h want 000000aa", dut.D_out_din); end
    end
  endtask

  initial begin
    int idx;
    idx = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j <= i; j++) begin
        gold[idx] = golden(i, j);
        idx++;
      end
    test_reset();
    test_first_words();
    test_back_to_back();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
